// File: rtl/fluid_fw_image_loader_if.sv
// Byte-stream input and Nios RAM second-port (s2) bus of the firmware image loader.
// master = loader side, slave = stream source / RAM side.
interface fluid_fw_image_loader_if #(
  parameter int ADDR_W = 15
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_write;
  logic [31:0]       m_writedata;
  logic              m_clken;
  logic [31:0]       m_readdata;

  modport master (
    input  s_data, s_valid, m_readdata,
    output s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );
  modport slave (
    output s_data, s_valid, m_readdata,
    input  s_ready, m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );
endinterface

// File: rtl/fluid_fw_image_loader.sv
// Framed firmware byte stream -> 32-bit LE words into the Nios RAM, CPU held in reset meanwhile.
// Optional readback check of the written region: define FW_LOADER_READBACK_VERIFY_EN.
module fluid_fw_image_loader #(
  parameter int         ADDR_W    = 15,
  parameter int         MEM_WORDS = 24576,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  fluid_fw_image_loader_if.master bus,
  output logic                    cpu_reset_req,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_DATA, ST_WR, ST_CHK,
`ifdef FW_LOADER_READBACK_VERIFY_EN
    ST_VERIFY,
`endif
    ST_FINISH, ST_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        hdr_cnt_q, hdr_cnt_d, byte_cnt_q, byte_cnt_d;
  logic [23:0]       hdr_q, hdr_d, data_q, data_d;
  logic [15:0]       len_q, len_d, word_cnt_q, word_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              s_ready_q, s_ready_d, cs_q, cs_d, we_q, we_d, clken_q, clken_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              accept;
  logic [15:0]       addr16, len16;
  logic [16:0]       end17;
`ifdef FW_LOADER_READBACK_VERIFY_EN
  logic [ADDR_W-1:0] start_q, start_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [7:0]        hdr_sum_q, hdr_sum_d, chk_q, chk_d, rb_sum_q, rb_sum_d, rd_bsum, v_sum;
  // [0]: read address on the bus this cycle, [1]: its data on m_readdata this cycle
  logic [1:0]        vld_pipe_q, vld_pipe_d;

  assign rd_bsum = bus.m_readdata[7:0] + bus.m_readdata[15:8]
                 + bus.m_readdata[23:16] + bus.m_readdata[31:24];
`else
  logic unused_rd;
  assign unused_rd = ^bus.m_readdata;
`endif

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    sum_d      = sum_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    busy_d     = busy_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    done_d     = 1'b0;
    clken_d    = 1'b1;
`ifdef FW_LOADER_READBACK_VERIFY_EN
    start_d    = start_q;
    rd_cnt_d   = rd_cnt_q;
    hdr_sum_d  = hdr_sum_q;
    chk_d      = chk_q;
    rb_sum_d   = rb_sum_q;
    v_sum      = 8'd0;
`endif
    accept = bus.s_valid & s_ready_q;
    addr16 = hdr_q[15:0];
    len16  = {bus.s_data, hdr_q[23:16]};
    end17  = {1'b0, addr16} + {1'b0, len16};

    case (state_q)
      ST_IDLE: if (accept && bus.s_data == SYNC_BYTE) begin
        error_d    = 1'b0;
        err_code_d = 2'd0;
        busy_d     = 1'b1;
        cpu_rst_d  = 1'b1;
        sum_d      = 8'd0;
        hdr_cnt_d  = 2'd0;
        byte_cnt_d = 2'd0;
        word_cnt_d = 16'd0;
        state_d    = ST_HDR;
      end
      ST_HDR: if (accept) begin
        hdr_d     = {bus.s_data, hdr_q[23:8]};
        sum_d     = sum_q + bus.s_data;
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        if (hdr_cnt_q == 2'd3) begin
          // address must fit the port and the whole image must end at or below MEM_WORDS
          if (len16 == 16'd0 || (addr16 >> ADDR_W) != 16'd0 || end17 > 17'(MEM_WORDS)) begin
            err_code_d = 2'd1;
            state_d    = ST_ERR;
          end else begin
            addr_d  = addr16[ADDR_W-1:0];
            len_d   = len16;
            state_d = ST_DATA;
`ifdef FW_LOADER_READBACK_VERIFY_EN
            start_d   = addr16[ADDR_W-1:0];
            hdr_sum_d = sum_d;
`endif
          end
        end
      end
      ST_DATA: if (accept) begin
        data_d     = {bus.s_data, data_q[23:8]};
        sum_d      = sum_q + bus.s_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          wdata_d = {bus.s_data, data_q};
          cs_d    = 1'b1;
          we_d    = 1'b1;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        word_cnt_d = word_cnt_q + 16'd1;
        // hold the address on the last word so it never points past the image
        if (word_cnt_d == len_q) state_d = ST_CHK;
        else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_DATA;
        end
      end
      ST_CHK: if (accept) begin
        sum_d = sum_q + bus.s_data;
        if (sum_d != 8'd0) begin
          err_code_d = 2'd2;
          state_d    = ST_ERR;
        end else begin
`ifdef FW_LOADER_READBACK_VERIFY_EN
          chk_d      = bus.s_data;
          cs_d       = 1'b1;
          addr_d     = start_q;
          rd_cnt_d   = 16'd1;
          word_cnt_d = 16'd0;
          rb_sum_d   = 8'd0;
          state_d    = ST_VERIFY;
`else
          state_d = ST_FINISH;
`endif
        end
      end
`ifdef FW_LOADER_READBACK_VERIFY_EN
      ST_VERIFY: begin
        if (rd_cnt_q != len_q) begin
          cs_d     = 1'b1;
          addr_d   = addr_q + ADDR_W'(1);
          rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (vld_pipe_q[1]) begin
          rb_sum_d   = rb_sum_q + rd_bsum;
          word_cnt_d = word_cnt_q + 16'd1;
          v_sum      = rb_sum_d + chk_q + hdr_sum_q;
          if (word_cnt_d == len_q) begin
            if (v_sum == 8'd0) state_d = ST_FINISH;
            else begin
              err_code_d = 2'd3;
              state_d    = ST_ERR;
            end
          end
        end
      end
`endif
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // status outputs are registered, so they follow the state being entered
    if (state_d == ST_FINISH) begin
      done_d    = 1'b1;
      busy_d    = 1'b0;
      cpu_rst_d = 1'b0;
    end
    if (state_d == ST_ERR) begin
      error_d = 1'b1;
      busy_d  = 1'b0;
    end
    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_HDR) ||
                (state_d == ST_DATA) || (state_d == ST_CHK);
    be_d = cs_d ? 4'hF : 4'h0;
`ifdef FW_LOADER_READBACK_VERIFY_EN
    vld_pipe_d = {vld_pipe_q[0], cs_d & ~we_d};
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hdr_cnt_q  <= '0;
      byte_cnt_q <= '0;
      hdr_q      <= '0;
      data_q     <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      sum_q      <= '0;
      s_ready_q  <= 1'b0;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      clken_q    <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
`ifdef FW_LOADER_READBACK_VERIFY_EN
      start_q    <= '0;
      rd_cnt_q   <= '0;
      hdr_sum_q  <= '0;
      chk_q      <= '0;
      rb_sum_q   <= '0;
      vld_pipe_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_q      <= hdr_d;
      data_q     <= data_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      sum_q      <= sum_d;
      s_ready_q  <= s_ready_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      clken_q    <= clken_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
`ifdef FW_LOADER_READBACK_VERIFY_EN
      start_q    <= start_d;
      rd_cnt_q   <= rd_cnt_d;
      hdr_sum_q  <= hdr_sum_d;
      chk_q      <= chk_d;
      rb_sum_q   <= rb_sum_d;
      vld_pipe_q <= vld_pipe_d;
`endif
    end
  end

  assign bus.s_ready      = s_ready_q;
  assign bus.m_address    = addr_q;
  assign bus.m_byteenable = be_q;
  assign bus.m_chipselect = cs_q;
  assign bus.m_write      = we_q;
  assign bus.m_writedata  = wdata_q;
  assign bus.m_clken      = clken_q;
  assign cpu_reset_req    = cpu_rst_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign err_code         = err_code_q;
endmodule

// File: tb/tb_fluid_fw_image_loader.sv
// Self-checking bench: random framed images with valid gaps against a frame-rule model and a RAM model.
module tb_fluid_fw_image_loader;
  localparam int ADDR_W    = 15;
  localparam int MEM_WORDS = 24576;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_reset_req, busy, done, error;
  logic [1:0] err_code;
  int cmp = 0, bad = 0;

  fluid_fw_image_loader_if #(.ADDR_W(ADDR_W)) bif ();

  fluid_fw_image_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif), .cpu_reset_req(cpu_reset_req),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // RAM model: write on the strobe cycle, read data one cycle after the address cycle
  logic [31:0] ram [0:MEM_WORDS-1];
  bit force_en = 1'b0;
  int force_addr = 0;
  always @(posedge clk) begin
    if (bif.m_chipselect && bif.m_write && int'(bif.m_address) < MEM_WORDS)
      ram[bif.m_address] <= bif.m_writedata;
    if (bif.m_chipselect && !bif.m_write && int'(bif.m_address) < MEM_WORDS)
      bif.m_readdata <= ram[bif.m_address] ^ {31'd0, force_en && int'(bif.m_address) == force_addr};
  end

  int cyc = 0, n_wr = 0, n_rd = 0, n_done = 0, cpu_hi = 0, be_viol = 0, addr_viol = 0;
  int rd_first_cyc = 0, done_cyc = 0;
  bit prev_rd = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bif.m_chipselect && bif.m_write) n_wr++;
    if (bif.m_chipselect && !bif.m_write) begin
      n_rd++;
      if (!prev_rd) rd_first_cyc = cyc;
    end
    prev_rd = bif.m_chipselect && !bif.m_write;
    if (done) begin n_done++; done_cyc = cyc; end
    if (cpu_reset_req) cpu_hi++;
    if (bif.m_byteenable !== (bif.m_chipselect ? 4'hF : 4'h0)) be_viol++;
    if (bif.m_chipselect && int'(bif.m_address) >= MEM_WORDS) addr_viol++;
  end

  logic [31:0] wq[$];

  // Frame rules: 1 = range/length, 2 = checksum, 3 = readback, 0 = loaded
  function automatic int exp_code(int a, int l, bit chk_ok, bit corrupt);
    if (l == 0 || a >= (1 << ADDR_W) || a + l > MEM_WORDS) return 1;
    if (!chk_ok) return 2;
`ifdef FW_LOADER_READBACK_VERIFY_EN
    if (corrupt) return 3;
`else
    if (corrupt) return 0;
`endif
    return 0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bif.s_data = b; bif.s_valid = 1'b1;
    @(negedge clk);
    while (!bif.s_ready && n < 100) begin @(negedge clk); n++; end
    if (!bif.s_ready) begin
      cmp++; bad++;
      $display("FAIL send_byte_timeout: s_ready=%b want 1", bif.s_ready);
    end
    @(posedge clk); #1;
    bif.s_valid = 1'b0; bif.s_data = 8'($urandom);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] l, input logic [7:0] dlt, input bit hdr_only);
    logic [7:0] s;
    logic [31:0] w;
    s = a[7:0] + a[15:8] + l[7:0] + l[15:8];
    foreach (wq[k]) begin w = wq[k]; s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24]; end
    send_byte(8'hA5);
    send_byte(a[7:0]); send_byte(a[15:8]); send_byte(l[7:0]); send_byte(l[15:8]);
    if (!hdr_only) begin
      foreach (wq[k]) begin
        w = wq[k];
        send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
      end
      send_byte(8'h00 - s + dlt);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (busy) begin
      cmp++; bad++;
      $display("FAIL wait_idle_timeout: busy=%b want 0", busy);
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bif.s_valid = 1'b0; bif.s_data = 8'h00;
    #2;
    cmp++; if ({bif.s_ready, bif.m_clken, bif.m_chipselect, bif.m_write} !== 4'b0000) begin bad++; $display("FAIL reset_bus: got %b want 0000", {bif.s_ready, bif.m_clken, bif.m_chipselect, bif.m_write}); end
    cmp++; if ({busy, done, error, cpu_reset_req, err_code} !== 6'd0) begin bad++; $display("FAIL reset_status: got %b want 000000", {busy, done, error, cpu_reset_req, err_code}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    send_byte(8'h00); send_byte(8'h11);
    @(negedge clk);
    cmp++; if (bif.s_ready !== 1'b1) begin bad++; $display("FAIL idle_s_ready: got %b want 1", bif.s_ready); end
    cmp++; if (bif.m_clken !== 1'b1) begin bad++; $display("FAIL idle_m_clken: got %b want 1", bif.m_clken); end
    cmp++; if ({busy, done, error, cpu_reset_req, err_code} !== 6'd0) begin bad++; $display("FAIL idle_status: got %b want 000000", {busy, done, error, cpu_reset_req, err_code}); end
    cmp++; if ({bif.m_chipselect, bif.m_byteenable, bif.m_address, bif.m_writedata} !== '0) begin bad++; $display("FAIL idle_bus: cs=%b be=%h addr=%h wd=%h want all 0", bif.m_chipselect, bif.m_byteenable, bif.m_address, bif.m_writedata); end
    cmp++; if (n_wr !== 0) begin bad++; $display("FAIL idle_writes: got %0d want 0", n_wr); end
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    int w0, d0, c0, r0;
    wq = '{32'h12345678, 32'hDEADBEEF};
    w0 = n_wr; d0 = n_done; c0 = cpu_hi; r0 = n_rd;
    send_frame(16'h0010, 16'd2, 8'h00, 1'b0);
    wait_idle();
    cmp++; if (ram[16] !== 32'h12345678) begin bad++; $display("FAIL good_word0: got %h want 12345678", ram[16]); end
    cmp++; if (ram[17] !== 32'hDEADBEEF) begin bad++; $display("FAIL good_word1: got %h want deadbeef", ram[17]); end
    cmp++; if (n_wr - w0 !== 2) begin bad++; $display("FAIL good_writes: got %0d want 2", n_wr - w0); end
    cmp++; if (n_done - d0 !== 1) begin bad++; $display("FAIL good_done: got %0d want 1", n_done - d0); end
    cmp++; if (!(cpu_hi > c0) || cpu_reset_req !== 1'b0) begin bad++; $display("FAIL good_cpu_reset: high_cycles=%0d now=%b want >0 then 0", cpu_hi - c0, cpu_reset_req); end
    cmp++; if ({error, err_code, busy} !== 4'd0) begin bad++; $display("FAIL good_status: got %b want 0000", {error, err_code, busy}); end
    cmp++; if (be_viol !== 0) begin bad++; $display("FAIL good_byteenable: violations %0d want 0", be_viol); end
`ifdef FW_LOADER_READBACK_VERIFY_EN
    cmp++; if (n_rd - r0 !== 2) begin bad++; $display("FAIL good_reads: got %0d want 2", n_rd - r0); end
`else
    cmp++; if (n_rd - r0 !== 0) begin bad++; $display("FAIL good_reads: got %0d want 0", n_rd - r0); end
`endif
  endtask

  task automatic test_bad_chk();
    int w0, d0;
    wq = '{32'hCAFEF00D, 32'h0BADBEEF};
    w0 = n_wr; d0 = n_done;
    send_frame(16'h0010, 16'd2, 8'h01, 1'b0);
    wait_idle();
    cmp++; if (n_wr - w0 !== 2 || ram[17] !== 32'h0BADBEEF) begin bad++; $display("FAIL badchk_writes: got %0d/%h want 2/0badbeef", n_wr - w0, ram[17]); end
    cmp++; if ({error, err_code} !== 3'b110) begin bad++; $display("FAIL badchk_code: got %b/%0d want 1/2", error, err_code); end
    cmp++; if (cpu_reset_req !== 1'b1) begin bad++; $display("FAIL badchk_cpu_reset: got %b want 1", cpu_reset_req); end
    cmp++; if (n_done - d0 !== 0) begin bad++; $display("FAIL badchk_done: got %0d want 0", n_done - d0); end
  endtask

  task automatic test_range();
    int w0, d0;
    int ta[3] = '{32'h5FFF, 32'h0020, 32'h8000};
    int tl[3] = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      wq.delete();
      w0 = n_wr; d0 = n_done;
      send_frame(16'(ta[i]), 16'(tl[i]), 8'h00, 1'b1);
      wait_idle();
      cmp++; if ({error, err_code} !== 3'b101 || n_wr - w0 !== 0 || n_done - d0 !== 0) begin bad++; $display("FAIL range_%0d: err=%b code=%0d writes=%0d done=%0d want 1/1/0/0", i, error, err_code, n_wr - w0, n_done - d0); end
    end
    wq = '{32'h01020304, 32'hA5A5A5A5};
    d0 = n_done;
    send_frame(16'h5FFE, 16'd2, 8'h00, 1'b0);
    wait_idle();
    cmp++; if (ram[MEM_WORDS-1] !== 32'hA5A5A5A5 || n_done - d0 !== 1 || error !== 1'b0) begin bad++; $display("FAIL range_top_fit: word=%h done=%0d err=%b want a5a5a5a5/1/0", ram[MEM_WORDS-1], n_done - d0, error); end
    cmp++; if (addr_viol !== 0) begin bad++; $display("FAIL range_addr_bound: violations %0d want 0", addr_viol); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int sel, a, l, code, w0, d0;
      logic [7:0] dl;
      l = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) l = 0;
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? int'($urandom_range(0, MEM_WORDS - 6)) :
          (sel == 2) ? MEM_WORDS - int'($urandom_range(0, 6)) : int'($urandom_range(0, 65535));
      dl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      code = exp_code(a, l, dl == 8'h00, 1'b0);
      wq.delete();
      for (int k = 0; k < l; k++) wq.push_back($urandom);
      w0 = n_wr; d0 = n_done;
      send_frame(16'(a), 16'(l), dl, code == 1);
      wait_idle();
      cmp++; if (int'(err_code) !== code || error !== (code != 0)) begin bad++; $display("FAIL rand_%0d_code: a=%h l=%0d err=%b code=%0d want code %0d", i, a, l, error, err_code, code); end
      cmp++; if (n_done - d0 !== int'(code == 0) || cpu_reset_req !== (code != 0)) begin bad++; $display("FAIL rand_%0d_done: done=%0d cpu=%b want %0d/%0d", i, n_done - d0, cpu_reset_req, code == 0, code != 0); end
      cmp++; if (n_wr - w0 !== ((code == 1) ? 0 : l)) begin bad++; $display("FAIL rand_%0d_writes: got %0d want %0d", i, n_wr - w0, (code == 1) ? 0 : l); end
      if (code != 1)
        for (int k = 0; k < l; k++) begin
          cmp++; if (ram[a+k] !== wq[k]) begin bad++; $display("FAIL rand_%0d_mem[%h]: got %h want %h", i, a + k, ram[a+k], wq[k]); end
        end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    bif.s_data = 8'h33; bif.s_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    cmp++; if ({bif.s_ready, bif.m_clken, bif.m_chipselect, busy, cpu_reset_req, error} !== 6'd0) begin bad++; $display("FAIL midreset_values: got %b want 000000", {bif.s_ready, bif.m_clken, bif.m_chipselect, busy, cpu_reset_req, error}); end
    bif.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    wq = '{$urandom, $urandom};
    d0 = n_done;
    send_frame(16'h0040, 16'd2, 8'h00, 1'b0);
    wait_idle();
    cmp++; if (ram[64] !== wq[0] || ram[65] !== wq[1]) begin bad++; $display("FAIL midreset_reload: got %h %h want %h %h", ram[64], ram[65], wq[0], wq[1]); end
    cmp++; if (n_done - d0 !== 1 || error !== 1'b0) begin bad++; $display("FAIL midreset_done: done=%0d err=%b want 1/0", n_done - d0, error); end
  endtask

`ifdef FW_LOADER_READBACK_VERIFY_EN
  task automatic test_verify();
    int a, d0, r0;
    a = $urandom_range(0, 1000);
    wq = '{$urandom, $urandom, $urandom};
    force_en = 1'b1; force_addr = a + 1;
    d0 = n_done;
    send_frame(16'(a), 16'd3, 8'h00, 1'b0);
    wait_idle();
    force_en = 1'b0;
    cmp++; if ({error, err_code} !== 3'b111 || n_done - d0 !== 0 || cpu_reset_req !== 1'b1) begin bad++; $display("FAIL verify_corrupt: err=%b code=%0d done=%0d cpu=%b want 1/3/0/1", error, err_code, n_done - d0, cpu_reset_req); end
    d0 = n_done; r0 = n_rd;
    send_frame(16'(a), 16'd3, 8'h00, 1'b0);
    wait_idle();
    cmp++; if ({error, err_code} !== 3'b000 || n_done - d0 !== 1) begin bad++; $display("FAIL verify_clean: err=%b code=%0d done=%0d want 0/0/1", error, err_code, n_done - d0); end
    cmp++; if (n_rd - r0 !== 3 || done_cyc - rd_first_cyc !== 4) begin bad++; $display("FAIL verify_cycles: reads=%0d span=%0d want 3/4", n_rd - r0, done_cyc - rd_first_cyc); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_range();
    test_random();
    test_reset_mid();
`ifdef FW_LOADER_READBACK_VERIFY_EN
    test_verify();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fluid_fw_image_loader.md
Name: fluid_fw_image_loader

Overview:
- Upstream feeder for the Nios on-chip program/data RAM second port (s2): receives a framed firmware image as a byte stream, assembles 32-bit little-endian words and writes them into the RAM.
- Checks a frame checksum; optionally re-reads the written region to confirm it.
- Holds the CPU in reset while loading so the core never fetches a half-written image.

Parameters:
ADDR_W, 15, word-address width of the RAM port
MEM_WORDS, 24576, number of 32-bit words in the RAM; upper bound for range check
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
s_data  input  8  incoming byte
s_valid  input  1  s_data valid
s_ready  output  1  byte accepted when s_valid & s_ready
m_address  output  ADDR_W  RAM word address
m_byteenable  output  4  always 4'hF when m_chipselect=1, else 4'h0
m_chipselect  output  1  RAM access strobe
m_write  output  1  write strobe (qualified by m_chipselect)
m_writedata  output  32  assembled word
m_clken  output  1  RAM clock enable; constant 1 after reset
m_readdata  input  32  RAM read data; valid the cycle after the address/chipselect cycle
cpu_reset_req  output  1  hold Nios in reset while loading
busy  output  1  frame in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky error flag
err_code  output  2  0 none, 1 range/length, 2 checksum, 3 verify

Behaviour:
- Single clock domain, clk. reset_n is asynchronous, active-low. All outputs are registered and reset to 0, except m_clken (reset 0, then 1). The FSM resets to IDLE.
- Frame format: SYNC_BYTE, addr_lo, addr_hi, len_lo, len_hi, then 4*len data bytes (LSB first per word), then chk. Valid frame: 8-bit sum of all bytes after SYNC, including chk, equals 0.
- States: IDLE, HDR, DATA, WR, CHK, VERIFY, FINISH, ERR.
- IDLE: s_ready=1. Non-SYNC bytes are discarded. On SYNC: clear error/err_code, set busy and cpu_reset_req, clear sum and counters, go to HDR.
- HDR: capture 4 bytes. addr is ADDR_W bits taken from the 16-bit field; the upper bits must be 0.
  - If len==0, addr upper bits are nonzero, or addr+len > MEM_WORDS (17-bit compare, no wrap): go to ERR, code 1.
  - Otherwise go to DATA.
- DATA: shift bytes into the word register. After the 4th byte go to WR.
- WR: exactly one cycle. m_chipselect=1, m_write=1, s_ready=0. m_address then increments. After len words go to CHK, else back to DATA.
- CHK: accept one byte.
  - Sum != 0: go to ERR, code 2. RAM contents written so far are left as-is.
  - Sum == 0: go to VERIFY if the feature is compiled in, else FINISH.
- FINISH: one cycle. done=1, busy=0, cpu_reset_req=0. Go to IDLE.
- ERR: one cycle. error=1 (sticky until the next SYNC), busy=0. cpu_reset_req stays 1 so a bad image never runs. Go to IDLE.
- s_ready is 0 in WR, VERIFY, FINISH and ERR.
- Sum arithmetic is modulo 256. The word counter is 16 bits. m_address never exceeds MEM_WORDS-1 because of the range check.
- Reset mid-frame: everything returns to reset values. The partial image stays in RAM; cpu_reset_req drops to 0 under reset. Upstream must reload.
- An s_valid byte presented while s_ready=0 is held by the source (standard valid/ready); no byte is lost or duplicated.

Optional Feature:
FW_LOADER_READBACK_VERIFY_EN
- Defined:
  - The VERIFY state re-issues the start address and reads len words back-to-back: m_chipselect=1, m_write=0, one address per cycle.
  - Each returned word is summed bytewise one cycle later (pipelined, latency 1), over len+1 cycles total.
  - The readback byte sum plus chk must equal 0 minus the header-byte sum.
  - Mismatch goes to ERR, code 3; match goes to FINISH.
- Not defined: the VERIFY state, its datapath and the code-3 path are absent; CHK goes straight to FINISH.

Test Plan:
- Reset release, idle bytes 0x00,0x11 -> discarded; all outputs 0 except m_clken=1 and s_ready=1.
- Frame addr=0x0010, len=2, data 78 56 34 12 EF BE AD DE, correct chk -> writes 0x12345678@0x10 and 0xDEADBEEF@0x11, m_byteenable=F, done pulse, cpu_reset_req 1->0, error=0.
- Same frame with chk+1 -> both words written, error=1, err_code=2, cpu_reset_req stays 1, no done.
- addr=0x5FFF, len=2 (exceeds 24576) -> ERR after len_hi, err_code=1, zero RAM writes; len=0 -> err_code=1.
- s_valid toggled randomly plus reset_n pulsed mid-DATA -> immediate reset values; next valid frame loads correctly.
- With FW_LOADER_READBACK_VERIFY_EN, RAM model forces bit 0 of one word -> err_code=3; unforced -> done after len+1 verify cycles.
